alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single LC-3b ALU between two requesters: port 0 (CPU datapath) and port 1 (address/aux unit).
//  Per-cycle valid/ready arbitration; drives the ALU operands and aluop from the winner.
//  Registers the ALU result, so each request completes with 1-cycle latency.
//  Optional lock lets one requester own the ALU for a bounded burst of back-to-back ops.
// PARAMETERS
//  MAX_LOCK  4                          max consecutive grants to a locked owner while the other port waits (>=1)
//  CNT_W     $clog2(MAX_LOCK+1)         width of the consecutive-grant counter (derived, do not override)
// PORTS
//  clk         in   1            rising-edge clock; single clock domain
//  rst         in   1            synchronous, active-high reset
//  req0_valid  in   1            port 0 request; held stable until req0_ready
//  req0_aluop  in   lc3b_aluop   port 0 operation
//  req0_a      in   16           port 0 operand a (lc3b_word)
//  req0_b      in   16           port 0 operand b (lc3b_word)
//  req0_lock   in   1            port 0 asks to keep the ALU next cycle
//  req0_ready  out  1            port 0 request accepted this cycle (comb.)
//  req1_*      --   --           identical set for port 1 (valid, aluop, a, b, lock, ready)
//  alu_aluop   out  lc3b_aluop   to ALU aluop
//  alu_a       out  16           to ALU a
//  alu_b       out  16           to ALU b
//  alu_f       in   16           from ALU f
//  resp0_valid out  1            1-cycle pulse: port 0 result on resp_f
//  resp1_valid out  1            1-cycle pulse: port 1 result on resp_f
//  resp_f      out  16           registered ALU result (shared by both ports)
// BEHAVIOUR
//  Reset
//  - resp0/1_valid=0, resp_f=0, owner=none, lock_cnt=0, last_grant=1 (port 0 wins first tie).
//  Grant (comb., at most one per cycle)
//  - Locked owner with valid=1 wins, unless lock_cnt==MAX_LOCK and the other port is valid.
//  - Otherwise a sole valid port wins.
//  - If both are valid: tie-break (see CONFIGURATION).
//  - reqN_ready=1 only for the winner.
//  ALU drive
//  - Winner's aluop/a/b go to alu_*.
//  - With no grant: alu_aluop=alu_pass, alu_a=alu_b=0.
//  Response
//  - On a grant edge: resp_f<=alu_f; respN_valid<=1 for the winner, 0 otherwise.
//  - Latency exactly 1 cycle; throughput 1 op/cycle; responses cannot be back-pressured.
//  Lock state (updated on the clock edge)
//  - Grant to N with reqN_lock=1: owner<=N.
//  - Grant to N with lock=0, or owner's valid=0: owner<=none.
//  - Forced release (other port wins): owner<=none.
//  lock_cnt
//  - Grant to the same port as last cycle: +1, saturating at MAX_LOCK.
//  - Grant to a different port, or an idle cycle: reset to 1 / 0 respectively.
//  Boundary cases
//  - Lock requested by port 1 while port 0 is also locked: impossible; only the winner's lock is sampled.
//  - Owner valid drops mid-burst: the other port may win the same cycle.
//  - rst mid-request: any pending resp is dropped, with no pulse the cycle after reset.
//  - Unknown aluop: passed through unchanged; the ALU flags it.
// CONFIGURATION
//  `ALU_ARB_RR_EN defined
//  - Round-robin tie-break: the port != last_grant wins.
//  - last_grant updates on every grant.
//  `ALU_ARB_RR_EN undefined
//  - Fixed priority: port 0 always wins ties.
//  - Port 1 can be starved except via MAX_LOCK forced release of a port 0 lock.
//  - last_grant is unused.
// STRUCTURE
//  lc3b_types
//  - Add typedef struct packed {lc3b_aluop aluop; lc3b_word a, b; logic lock;} lc3b_alu_req.
//  - Add enum lc3b_alu_port {port0, port1}.
//  Sub-module
//  - alu_arb_pick: combinational winner select from valids, owner, lock_cnt, last_grant.
//  - Owner, lock_cnt and response registers stay in alu_arbiter.
// TESTING
//  1 Reset, then only req0 valid: add a=0x0003 b=0x0004 -> ready0=1 that cycle; next cycle resp0_valid=1, resp_f=0x0007.
//  2 Both valid every cycle, no lock, RR on -> grants 0,1,0,1; with RR off -> 0,0,0,0.
//  3 Port 0 lock=1, MAX_LOCK=4, port 1 valid -> grants 0,0,0,0,1; lock_cnt saturates at 4 and port 0 loses ownership.
//  4 Owner drops valid mid-lock -> port 1 is granted the same cycle; owner=none.
//  5 Grant on port 1 (sra a=0x8000 b=4), rst asserted next edge -> no resp1_valid; resp_f=0.
//  6 Idle cycle -> alu_aluop=alu_pass, alu_a=alu_b=0, both resp_valid=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg : LC-3b ALU types shared by the arbiter and its selector
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package alu_arbiter_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra
  } lc3b_aluop;

  typedef enum logic {
    port0,
    port1
  } lc3b_alu_port;

  typedef struct packed {
    lc3b_aluop aluop;
    lc3b_word  a;
    lc3b_word  b;
    logic      lock;
  } lc3b_alu_req;

  function automatic lc3b_alu_port other_port(input lc3b_alu_port p);
    return (p == port0) ? port1 : port0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_pick.sv
// ---------------------------------------------------------------------------
// alu_arb_pick : combinational winner select (lock owner, sole valid, tie-break)
// Tie-break is round-robin when ALU_ARB_RR_EN is defined, else port 0 wins.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arb_pick
  import alu_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4,
  parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
  input  logic             valid0,
  input  logic             valid1,
  input  logic             owner_valid,
  input  lc3b_alu_port     owner,
  input  logic [CNT_W-1:0] lock_cnt,
  input  lc3b_alu_port     last_grant,
  output logic             grant,
  output lc3b_alu_port     grant_port
);

  logic owner_req;
  logic other_req;

  assign owner_req = owner_valid && ((owner == port0) ? valid0 : valid1);
  assign other_req = (owner == port0) ? valid1 : valid0;

  always_comb begin
    grant      = 1'b0;
    grant_port = port0;
    if (owner_req) begin
      grant      = 1'b1;
      // A saturated burst yields to a waiting peer.
      grant_port = (lock_cnt == CNT_W'(MAX_LOCK) && other_req) ? other_port(owner) : owner;
    end else if (valid0 && valid1) begin
      grant = 1'b1;
`ifdef ALU_ARB_RR_EN
      grant_port = other_port(last_grant);
`else
      grant_port = port0;
`endif
    end else if (valid0) begin
      grant      = 1'b1;
      grant_port = port0;
    end else if (valid1) begin
      grant      = 1'b1;
      grant_port = port1;
    end
  end

`ifndef ALU_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter : shares one LC-3b ALU between two requesters, 1-cycle latency
// Optional round-robin tie-break via ALU_ARB_RR_EN.  Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4,
  parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req0_valid,
  input  lc3b_aluop req0_aluop,
  input  lc3b_word  req0_a,
  input  lc3b_word  req0_b,
  input  logic      req0_lock,
  output logic      req0_ready,
  input  logic      req1_valid,
  input  lc3b_aluop req1_aluop,
  input  lc3b_word  req1_a,
  input  lc3b_word  req1_b,
  input  logic      req1_lock,
  output logic      req1_ready,
  output lc3b_aluop alu_aluop,
  output lc3b_word  alu_a,
  output lc3b_word  alu_b,
  input  lc3b_word  alu_f,
  output logic      resp0_valid,
  output logic      resp1_valid,
  output lc3b_word  resp_f
);

  lc3b_alu_req      req0;
  lc3b_alu_req      req1;
  lc3b_alu_req      win;
  logic             grant;
  lc3b_alu_port     grant_port;
  logic             owner_valid;
  lc3b_alu_port     owner;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_next;
  lc3b_alu_port     last_grant;

  assign req0 = '{aluop: req0_aluop, a: req0_a, b: req0_b, lock: req0_lock};
  assign req1 = '{aluop: req1_aluop, a: req1_a, b: req1_b, lock: req1_lock};

  alu_arb_pick #(
    .MAX_LOCK (MAX_LOCK),
    .CNT_W    (CNT_W)
  ) u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .owner_valid (owner_valid),
    .owner       (owner),
    .lock_cnt    (lock_cnt),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_port  (grant_port)
  );

  assign win        = (grant_port == port1) ? req1 : req0;
  assign req0_ready = grant && (grant_port == port0);
  assign req1_ready = grant && (grant_port == port1);

  always_comb begin
    alu_aluop = alu_pass;
    alu_a     = '0;
    alu_b     = '0;
    if (grant) begin
      alu_aluop = win.aluop;
      alu_a     = win.a;
      alu_b     = win.b;
    end
  end

  // lock_cnt == 0 marks an idle previous cycle, so last_grant is only trusted when non-zero.
  always_comb begin
    lock_cnt_next = '0;
    if (grant) begin
      if (lock_cnt != '0 && grant_port == last_grant) begin
        lock_cnt_next = (lock_cnt == CNT_W'(MAX_LOCK)) ? lock_cnt : lock_cnt + CNT_W'(1);
      end else begin
        lock_cnt_next = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_f      <= '0;
      owner_valid <= 1'b0;
      owner       <= port0;
      lock_cnt    <= '0;
      last_grant  <= port1;
    end else begin
      resp0_valid <= req0_ready;
      resp1_valid <= req1_ready;
      lock_cnt    <= lock_cnt_next;
      owner_valid <= grant && win.lock;
      if (grant) begin
        resp_f     <= alu_f;
        owner      <= grant_port;
        last_grant <= grant_port;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter : directed + randomized checks against a behavioural model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int MAX_LOCK = 4;

  logic      clk = 1'b0;
  logic      rst;
  logic      req0_valid, req0_lock, req0_ready;
  lc3b_aluop req0_aluop;
  lc3b_word  req0_a, req0_b;
  logic      req1_valid, req1_lock, req1_ready;
  lc3b_aluop req1_aluop;
  lc3b_word  req1_a, req1_b;
  lc3b_aluop alu_aluop;
  lc3b_word  alu_a, alu_b, alu_f;
  logic      resp0_valid, resp1_valid;
  lc3b_word  resp_f;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner -1 = none; cnt = consecutive grants to the same port.
  int       m_owner, m_cnt, m_last;
  logic     exp_rv0, exp_rv1;
  lc3b_word exp_f;

  always #5 clk = ~clk;

  function automatic lc3b_word alu_ref(input lc3b_aluop op, input lc3b_word a, input lc3b_word b);
    case (op)
      alu_add:  return a + b;
      alu_and:  return a & b;
      alu_not:  return ~a;
      alu_pass: return a;
      alu_sll:  return a << b[3:0];
      alu_srl:  return a >> b[3:0];
      alu_sra:  return lc3b_word'($signed(a) >>> b[3:0]);
      default:  return a ^ b ^ 16'h5a5a;
    endcase
  endfunction

  assign alu_f = alu_ref(alu_aluop, alu_a, alu_b);

  alu_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_aluop(req0_aluop), .req0_a(req0_a), .req0_b(req0_b),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_aluop(req1_aluop), .req1_a(req1_a), .req1_b(req1_b),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_f(resp_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_f = '0;
  endfunction

  function automatic int model_pick(input logic v0, input logic v1);
    logic v[2];
    v[0] = v0; v[1] = v1;
    if (m_owner >= 0 && v[m_owner]) begin
      if (m_cnt >= MAX_LOCK && v[1 - m_owner]) return 1 - m_owner;
      return m_owner;
    end
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock cycle: drive, check the combinational grant, then check the registered response.
  task automatic step(input logic r,
                      input logic v0, input lc3b_aluop op0, input lc3b_word a0, input lc3b_word b0, input logic l0,
                      input logic v1, input lc3b_aluop op1, input lc3b_word a1, input lc3b_word b1, input logic l1,
                      output int w);
    lc3b_aluop eop;
    lc3b_word  ea, eb;
    rst = r;
    req0_valid = v0; req0_aluop = op0; req0_a = a0; req0_b = b0; req0_lock = l0;
    req1_valid = v1; req1_aluop = op1; req1_a = a1; req1_b = b1; req1_lock = l1;
    #3;
    w = model_pick(v0, v1);
    check("ready0", req0_ready, w == 0);
    check("ready1", req1_ready, w == 1);
    eop = (w == 0) ? op0 : (w == 1) ? op1 : alu_pass;
    ea  = (w == 0) ? a0  : (w == 1) ? a1  : 16'h0;
    eb  = (w == 0) ? b0  : (w == 1) ? b1  : 16'h0;
    check("alu_aluop", alu_aluop, eop);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    if (r) begin
      model_reset();
    end else begin
      exp_rv0 = (w == 0);
      exp_rv1 = (w == 1);
      if (w >= 0) begin
        exp_f   = alu_ref(eop, ea, eb);
        m_cnt   = (m_cnt > 0 && w == m_last) ? ((m_cnt < MAX_LOCK) ? m_cnt + 1 : MAX_LOCK) : 1;
        m_last  = w;
        m_owner = ((w == 0) ? l0 : l1) ? w : -1;
      end else begin
        m_cnt   = 0;
        m_owner = -1;
      end
    end
    @(posedge clk); #1;
    check("resp0_valid", resp0_valid, exp_rv0);
    check("resp1_valid", resp1_valid, exp_rv1);
    check("resp_f", resp_f, exp_f);
  endtask

  task automatic idle_reset();
    int w;
    step(1'b1, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, w);
  endtask

  initial begin
    int w;
    int seq[5];
    logic      p0v, p0l, p1v, p1l;
    lc3b_aluop p0o, p1o;
    lc3b_word  p0a, p0b, p1a, p1b;

    rst = 1'b1;
    req0_valid = 1'b0; req0_aluop = alu_add; req0_a = '0; req0_b = '0; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_aluop = alu_add; req1_a = '0; req1_b = '0; req1_lock = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp0_valid", resp0_valid, 1'b0);
    check("rst_resp1_valid", resp1_valid, 1'b0);
    check("rst_resp_f", resp_f, 16'h0);

    // Single add on port 0.
    step(1'b0, 1'b1, alu_add, 16'h0003, 16'h0004, 1'b0, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, w);
    check("t1_grant", w, 0);
    check("t1_resp_f", resp_f, 16'h0007);

    // Idle cycle: pass with zero operands, no response.
    step(1'b0, 1'b0, alu_add, 16'h1234, 16'h5678, 1'b0, 1'b0, alu_and, 16'h9abc, 16'hdef0, 1'b0, w);
    check("t6_aluop", alu_aluop, alu_pass);

    // Both valid, no lock.
    idle_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, alu_add, 16'(i), 16'h10, 1'b0, 1'b1, alu_and, 16'hffff, 16'(i), 1'b0, w);
`ifdef ALU_ARB_RR_EN
      check("t2_rr_grant", w, i % 2);
`else
      check("t2_fixed_grant", w, 0);
`endif
    end

    // Port 0 locked burst against a waiting port 1.
    idle_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, alu_add, 16'(i), 16'h1, 1'b1, 1'b1, alu_sll, 16'h1, 16'h3, 1'b0, w);
      seq[i] = w;
    end
    check("t3_g0", seq[0], 0);
    check("t3_g1", seq[1], 0);
    check("t3_g2", seq[2], 0);
    check("t3_g3", seq[3], 0);
    check("t3_g4", seq[4], 1);

    // Owner drops valid mid-lock.
    idle_reset();
    step(1'b0, 1'b1, alu_not, 16'h00f0, 16'h0, 1'b1, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, w);
    step(1'b0, 1'b0, alu_not, 16'h00f0, 16'h0, 1'b1, 1'b1, alu_srl, 16'hf000, 16'h4, 1'b0, w);
    check("t4_grant", w, 1);
    step(1'b0, 1'b1, alu_add, 16'h1, 16'h1, 1'b0, 1'b1, alu_add, 16'h2, 16'h2, 1'b0, w);
    check("t4_after", w, 0);

    // Reset on the edge that would complete a port 1 request.
    step(1'b0, 1'b1, alu_add, 16'h1111, 16'h2222, 1'b0, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, w);
    step(1'b1, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, 1'b1, alu_sra, 16'h8000, 16'h0004, 1'b0, w);
    check("t5_grant", w, 1);
    check("t5_resp_f", resp_f, 16'h0);
    step(1'b0, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, 1'b0, alu_add, 16'h0, 16'h0, 1'b0, w);
    check("t5_no_pulse", resp1_valid, 1'b0);

    // Randomized traffic; a pending request is held until accepted.
    p0v = 1'b0; p1v = 1'b0;
    p0o = alu_add; p1o = alu_add; p0a = '0; p0b = '0; p1a = '0; p1b = '0; p0l = 1'b0; p1l = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      if (!p0v) begin
        p0v = ($urandom_range(0, 3) != 0);
        p0o = lc3b_aluop'(4'($urandom_range(0, 8)));
        p0a = 16'($urandom); p0b = 16'($urandom); p0l = 1'($urandom);
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 3) != 0);
        p1o = lc3b_aluop'(4'($urandom_range(0, 8)));
        p1a = 16'($urandom); p1b = 16'($urandom); p1l = 1'($urandom);
      end
      r = ($urandom_range(0, 63) == 0);
      step(r, p0v, p0o, p0a, p0b, p0l, p1v, p1o, p1a, p1b, p1l, w);
      if (w == 0 || r) p0v = 1'b0;
      if (w == 1 || r) p1v = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
